bram_burst_reader: RTL and testbench

- Read-side counterpart of the team's one-shot BRAM writer.
- On a start edge, issues a burst of sequential 32-bit reads on a Xilinx-style BRAM port and presents the words on a valid/ready output stream.
- A small FIFO absorbs BRAM read latency and downstream backpressure.
- Feeds image/weight data from PS-loaded BRAM into the BNN datapath.

---
 rtl/bram_burst_reader_if.sv | 43 ++++
 rtl/bram_burst_reader.sv | 118 +++++++++++
 tb/tb_bram_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_burst_reader_if.sv
// Signal bundle for bram_burst_reader: BRAM port, start/status control and output stream.
// The master side is the reader; the slave side is the BRAM, controller and stream consumer.
interface bram_burst_reader_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              clka;
  logic              rsta;
  logic              ena;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic [3:0]        wea;
  logic [31:0]       douta;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              ready;
  logic              done;

  logic [31:0]       m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output clka, rsta, ena, addra, dina, wea,
    input  douta,
    input  start, base_addr, word_count,
    output ready, done,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  clka, rsta, ena, addra, dina, wea,
    output douta,
    output start, base_addr, word_count,
    input  ready, done,
    input  m_data, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst reader: on a start edge, reads word_count sequential 32-bit words from a BRAM port
// and streams them out through a small FIFO that absorbs read latency and backpressure.
module bram_burst_reader #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bram_burst_reader_if.master  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FINISH} state_t;

  state_t            state, state_nxt;
  logic              start_q;
  logic              start_edge;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  words_rem;
  logic              inflight;
  logic              inflight_last;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_valid;
  logic              head_last;

  logic [31:0]       data_mem [FIFO_DEPTH];
  logic              last_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;

  assign start_edge = bus.start & ~start_q;
  assign fifo_valid = (fifo_count != '0);
  assign head_last  = fifo_valid & last_mem[rd_ptr];
  assign push       = inflight;
  assign pop        = fifo_valid & bus.m_ready;

  // The read in flight already owns a FIFO slot, so it counts against the depth.
  assign issue = (state == S_READ) && (words_rem != '0) &&
                 ((fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH));

  assign bus.clka    = clk;
  assign bus.rsta    = ~rst_n;
  assign bus.ena     = issue;
  assign bus.addra   = addr;
  assign bus.dina    = '0;
  assign bus.wea     = '0;
  assign bus.ready   = (state == S_IDLE);
  assign bus.done    = (state == S_FINISH);
  assign bus.m_valid = fifo_valid;
  assign bus.m_data  = data_mem[rd_ptr];
  assign bus.m_last  = head_last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt = (bus.word_count == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        if (pop && head_last) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      start_q       <= 1'b0;
      addr          <= '0;
      words_rem     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      state         <= state_nxt;
      start_q       <= bus.start;
      inflight      <= issue;
      inflight_last <= issue && (words_rem == CNT_W'(1));

      if (state == S_IDLE && start_edge) begin
        addr      <= bus.base_addr & ~ADDR_W'(3);
        words_rem <= bus.word_count;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(4);
        words_rem <= words_rem - CNT_W'(1);
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.douta;
      last_mem[wr_ptr] <= inflight_last;
    end
  end
endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader: BRAM behavioural model, expected-word queues
// built from the burst rules, and randomized bursts and stream backpressure.
module tb_bram_burst_reader;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] salt;

  bram_burst_reader_if #(.ADDR_W(32), .CNT_W(16)) bus ();
  bram_burst_reader_if #(.ADDR_W(8),  .CNT_W(16)) bus8 ();

  bram_burst_reader #(.ADDR_W(32), .CNT_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  bram_burst_reader #(.ADDR_W(8), .CNT_W(16), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] bram_word(input logic [31:0] a);
    return (32'h100 + (a >> 2)) ^ salt;
  endfunction

  // One-cycle-latency BRAM models
  always @(posedge clk) if (bus.ena)  bus.douta  <= bram_word(bus.addra);
  always @(posedge clk) if (bus8.ena) bus8.douta <= 32'h800 + {24'h0, bus8.addra};

  // rmode: 0 ready always high, 1 stalled 6 cycles then toggling, 2 random
  // smode: 0 one-cycle pulse, 1 held through completion, 2 pulse plus a second pulse mid-burst
  task automatic run_burst(input logic [31:0] base, input int cnt, input int rmode,
                           input int smode, input string name);
    logic [31:0] exp_q[$];
    logic [31:0] abase;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    int issued, popped, first_valid, done_cyc;
    abase = base & ~32'h3;
    for (int i = 0; i < cnt; i++) exp_q.push_back(bram_word(abase + 32'(4 * i)));
    issued = 0; popped = 0; first_valid = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

    @(negedge clk);
    bus.base_addr  = base;
    bus.word_count = 16'(cnt);
    bus.start      = 1'b1;
    bus.m_ready    = (rmode == 0);

    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start   = (smode == 1) || (smode == 2 && cyc == 4);
      bus.m_ready = (rmode == 0) ? 1'b1 :
                    (rmode == 1) ? (cyc > 6 && (cyc % 2) == 1) : 1'($urandom_range(0, 1));

      if (cyc == 1) begin
        total++;
        if (bus.ready !== 1'b0 || bus.ena !== 1'b1) begin
          bad++;
          $display("FAIL %s launch: ready=%b ena=%b want ready=0 ena=1", name, bus.ready, bus.ena);
        end
      end

      if (bus.ena === 1'b1) begin
        issued++;
        total++;
        if (issued > cnt || bus.addra !== abase + 32'(4 * (issued - 1)) || issued - popped > 4) begin
          bad++;
          $display("FAIL %s read: issue=%0d addra=%h want %h outstanding=%0d max 4",
                   name, issued, bus.addra, abase + 32'(4 * (issued - 1)), issued - popped);
        end
      end

      if (prev_stall) begin
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
          bad++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                   name, bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
        end
      end

      if (rmode == 0 && first_valid > 0 && popped < cnt) begin
        total++;
        if (bus.m_valid !== 1'b1) begin
          bad++;
          $display("FAIL %s bubble: m_valid=%b at beat %0d want 1", name, bus.m_valid, popped);
        end
      end

      if (bus.m_valid === 1'b1 && first_valid < 0) first_valid = cyc;

      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        total++;
        if (popped >= cnt) begin
          bad++;
          $display("FAIL %s extra_beat: data=%h beyond %0d words", name, bus.m_data, cnt);
        end else if (bus.m_data !== exp_q[popped] || bus.m_last !== (popped == cnt - 1)) begin
          bad++;
          $display("FAIL %s beat%0d: data=%h last=%b want data=%h last=%b",
                   name, popped, bus.m_data, bus.m_last, exp_q[popped], (popped == cnt - 1));
        end
        popped++;
      end

      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        total++;
        if (popped != cnt || issued != cnt) begin
          bad++;
          $display("FAIL %s done_early: beats=%0d reads=%0d want %0d", name, popped, issued, cnt);
        end
      end

      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end

    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL %s timeout: beats=%0d want %0d, done never seen", name, popped, cnt);
    end

    if (rmode == 0) begin
      total++;
      if (first_valid != 3 || done_cyc != cnt + 3) begin
        bad++;
        $display("FAIL %s latency: first_valid=%0d done=%0d want 3 and %0d",
                 name, first_valid, done_cyc, cnt + 3);
      end
    end

    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      bus.start = (smode == 1);
      total++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.ena !== 1'b0 || bus.m_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s idle_after: ready=%b done=%b ena=%b valid=%b want 1 0 0 0",
                 name, bus.ready, bus.done, bus.ena, bus.m_valid);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
        bus.ena !== 1'b0 || bus.addra !== 32'h0 || bus.rsta !== 1'b1 || bus.wea !== 4'h0 ||
        bus.dina !== 32'h0) begin
      bad++;
      $display("FAIL reset: ready=%b done=%b valid=%b last=%b ena=%b addra=%h rsta=%b want 1 0 0 0 0 0 1",
               bus.ready, bus.done, bus.m_valid, bus.m_last, bus.ena, bus.addra, bus.rsta);
    end
    total++;
    if (bus8.ready !== 1'b1 || bus8.ena !== 1'b0 || bus8.addra !== 8'h0 || bus8.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset8: ready=%b ena=%b addra=%h valid=%b want 1 0 00 0",
               bus8.ready, bus8.ena, bus8.addra, bus8.m_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.rsta !== 1'b0 || bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: rsta=%b ready=%b want 0 1", bus.rsta, bus.ready);
    end
  endtask

  task automatic test_basic();
    salt = '0;
    run_burst(32'h10, 5, 0, 0, "basic");
  endtask

  task automatic test_backpressure();
    salt = 32'h5A5A_0000;
    run_burst(32'h200, 8, 1, 0, "backpressure");
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    bus.base_addr  = 32'h40;
    bus.word_count = '0;
    bus.start      = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if (bus.ena !== 1'b0 || bus.m_valid !== 1'b0 ||
          bus.done !== (cyc == 1) || bus.ready !== (cyc != 1)) begin
        bad++;
        $display("FAIL zero_count c%0d: ena=%b valid=%b done=%b ready=%b want 0 0 %b %b",
                 cyc, bus.ena, bus.m_valid, bus.done, bus.ready, (cyc == 1), (cyc != 1));
      end
    end
  endtask

  task automatic test_start_busy();
    salt = 32'h0000_7700;
    run_burst(32'h80, 6, 0, 2, "busy_pulse");
    run_burst(32'h180, 4, 2, 1, "held_start");
  endtask

  task automatic test_random_bursts();
    for (int k = 0; k < 6; k++) begin
      salt = $urandom;
      run_burst($urandom_range(0, 32'hFFFF), $urandom_range(1, 12), 2, 0, "random");
    end
    salt = $urandom;
    run_burst(32'hFFFF_FFF6, 6, 2, 0, "wrap32");
  endtask

  task automatic test_reset_mid();
    int beats;
    logic hit;
    salt  = '0;
    beats = 0;
    hit   = 1'b0;
    @(negedge clk);
    bus.base_addr  = 32'h40;
    bus.word_count = 16'd8;
    bus.start      = 1'b1;
    bus.m_ready    = 1'b1;
    for (int cyc = 1; cyc <= 50 && !hit; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.m_valid === 1'b1) beats++;
      if (beats == 3) begin
        rst_n = 1'b0;
        hit   = 1'b1;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reset_mid timeout: beats=%0d want 3", beats);
    end
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (bus.ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.ena !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b valid=%b ena=%b done=%b want 1 0 0 0",
               bus.ready, bus.m_valid, bus.ena, bus.done);
    end
    @(negedge clk);
    total++;
    if (bus.ena !== 1'b0 || bus.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_after: ena=%b valid=%b want 0 0", bus.ena, bus.m_valid);
    end
    run_burst(32'h0, 2, 0, 0, "post_reset");
  endtask

  task automatic test_addr_wrap();
    logic [7:0] wa [4];
    int na, nb;
    wa[0] = 8'hF8; wa[1] = 8'hFC; wa[2] = 8'h00; wa[3] = 8'h04;
    na = 0; nb = 0;
    @(negedge clk);
    bus8.base_addr  = 8'hF8;
    bus8.word_count = 16'd4;
    bus8.start      = 1'b1;
    bus8.m_ready    = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.ena === 1'b1) begin
        total++;
        if (na >= 4 || bus8.addra !== wa[na]) begin
          bad++;
          $display("FAIL wrap_addr%0d: addra=%h want %h", na, bus8.addra, (na < 4) ? wa[na] : 8'hxx);
        end
        na++;
      end
      if (bus8.m_valid === 1'b1) begin
        total++;
        if (nb >= 4 || bus8.m_data !== 32'h800 + {24'h0, wa[nb]} || bus8.m_last !== (nb == 3)) begin
          bad++;
          $display("FAIL wrap_beat%0d: data=%h last=%b want %h %b", nb, bus8.m_data, bus8.m_last,
                   (nb < 4) ? 32'h800 + {24'h0, wa[nb]} : 32'hx, (nb == 3));
        end
        nb++;
      end
    end
    total++;
    if (na != 4 || nb != 4 || bus8.ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_count: reads=%0d beats=%0d ready=%b want 4 4 1", na, nb, bus8.ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    salt  = '0;
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.base_addr = '0;  bus.word_count = '0;  bus.m_ready = 1'b0;
    bus8.start = 1'b0; bus8.base_addr = '0; bus8.word_count = '0; bus8.m_ready = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_start_busy();
    test_random_bursts();
    test_reset_mid();
    test_addr_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
